uart_transmitter_byte: RTL and testbench
========================================

// Module: uart_transmitter_byte
// PURPOSE
//  - Serialises bytes onto the UART line as 8N1 (start, DATA_BITS LSB-first, stop) at 19.2 kbaud.
//  - Timing from shared baud_tick strobe at 16x baud (307.2 kHz); counterpart of our UART receive path.
//  - Byte-level valid/ready input from host-side logic; drives the board TX pin.
// PARAMETERS
//  DATA_BITS   8      payload bits per frame
//  OVERSAMPLE  16     baud_ticks per bit period
//  STOP_BITS   1      stop bits per frame (1 or 2)
//  EOT_CHAR    8'h04  byte auto-appended when UART_TX_AUTO_EOT_EN defined
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous reset, active-low
//  baud_tick  in   1          one-clk strobe at 16x baud rate
//  tx_data    in   DATA_BITS  byte to send, sampled on accept
//  tx_valid   in   1          tx_data valid; hold until accepted
//  tx_last    in   1          last byte of message (used only with macro)
//  tx_ready   out  1          can accept a byte this cycle
//  tx         out  1          serial line, idle high
//  busy       out  1          frame in progress (START/DATA/STOP)
//  byte_done  out  1          one-clk pulse at end of each frame's stop period
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE, tx=1, busy=0, byte_done=0, counters 0, EOT pending cleared.
//    Reset mid-frame aborts immediately; line returns high on that edge.
//  - tx_ready = (state==IDLE) & ~eot_pending, combinational. Accept = tx_valid & tx_ready.
//  - On accept: latch tx_data into shift reg, tick counter=0, bit counter=0; next edge state START, tx=0, busy=1.
//    tx_data/tx_valid changes after accept have no effect. tx_valid while busy is held, not dropped.
//  - Tick counter 4b counts baud_ticks only when state!=IDLE; bit boundary = baud_tick with count==OVERSAMPLE-1,
//    count then wraps to 0. First (start) period may be up to one tick interval short (async to accept).
//  - FSM (registered state, tx registered, no glitches):
//    IDLE  -> START on accept.
//    START -> DATA at boundary; tx=shift[0].
//    DATA  at boundary: shift right, bit counter+1; after DATA_BITS-th bit -> STOP, tx=1.
//    STOP  after STOP_BITS boundaries -> IDLE; byte_done=1 for exactly that one clk; busy=0.
//  - Back-to-back: accept allowed in first IDLE cycle; tx stays 1 for >=1 clk between stop and next start.
//  - Latency: accept edge -> tx low next edge. Frame = (1+DATA_BITS+STOP_BITS)*OVERSAMPLE ticks (160 nominal).
//  - baud_tick coinciding with accept: not counted toward start period.
//  - Bit counter width $clog2(DATA_BITS+1); no wrap beyond DATA_BITS.
// CONFIGURATION
//  - Macro UART_TX_AUTO_EOT_EN:
//    defined: tx_last latched on accept; when that frame ends, eot_pending=1, tx_ready stays 0, and
//      EOT_CHAR frame starts in the cycle after STOP->IDLE without host action; byte_done pulses
//      for both frames; eot_pending clears on internal accept. Receiver flushes its check register on it.
//    undefined: tx_last ignored, eot_pending tied 0, host sends EOT_CHAR explicitly.
// TESTING
//  1. Reset rst=0 5 clks, tx_valid=1 -> tx=1, tx_ready=0 during reset, busy=0, no frame started.
//  2. Send 8'hA5 -> tx: 0 (start), 1,0,1,0,0,1,0,1 each 16 ticks, 1 for 16 ticks; byte_done one pulse;
//     loopback receiver recovers 8'hA5.
//  3. Hold tx_valid with 8'h31, 8'h32, 8'h33 queued -> three contiguous frames, each accepted in first IDLE cycle,
//     inter-frame idle-high 1 clk, bytes received in order.
//  4. Assert rst=0 mid-DATA of 8'h00 (tx low) -> tx=1 next edge, IDLE, tx_ready=1 after release, next byte 8'h55 clean.
//  5. Macro on: send 8'h41 with tx_last=1 -> frames 8'h41 then 8'h04 back-to-back, tx_ready=0 until EOT
//     stop ends, two byte_done pulses; with tx_last=0 only 8'h41 sent.
//  6. Macro off: 8'h41 with tx_last=1 -> single frame, tx_ready=1 right after byte_done.

Source files
------------

// File: rtl/uart_transmitter_byte.sv
// 8N1 UART byte transmitter paced by a shared 16x-baud strobe, with a valid/ready byte input.
// Optional macro UART_TX_AUTO_EOT_EN: appends EOT_CHAR after any byte accepted with tx_last set.
module uart_transmitter_byte #(
  parameter int unsigned          DATA_BITS  = 8,
  parameter int unsigned          OVERSAMPLE = 16,
  parameter int unsigned          STOP_BITS  = 1,
  parameter logic [DATA_BITS-1:0] EOT_CHAR   = DATA_BITS'(8'h04)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  input  logic                 tx_last,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_done
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 boundary;
  logic                 frame_end;
  logic                 eot_pending;
  logic                 eot_accept;
  logic                 host_accept;
  logic                 accept;
  logic [DATA_BITS-1:0] load_byte;

  assign boundary    = baud_tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));
  assign frame_end   = (state_q == STOP) && boundary && (stop_cnt_q == 1'(STOP_BITS - 1));
  assign tx_ready    = rst && (state_q == IDLE) && !eot_pending;
  assign host_accept = tx_valid && tx_ready;
  assign accept      = host_accept || eot_accept;
  assign load_byte   = eot_accept ? EOT_CHAR : tx_data;

`ifdef UART_TX_AUTO_EOT_EN
  logic eot_pending_q, eot_pending_d;
  logic last_q, last_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      eot_pending_q <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      eot_pending_q <= eot_pending_d;
      last_q        <= last_d;
    end
  end

  // The EOT frame itself is loaded with last cleared, so it never chains another EOT.
  always_comb begin
    last_d        = last_q;
    eot_pending_d = eot_pending_q;
    if (host_accept) begin
      last_d = tx_last;
    end else if (eot_accept) begin
      last_d = 1'b0;
    end
    if (frame_end && last_q) begin
      eot_pending_d = 1'b1;
    end else if (eot_accept) begin
      eot_pending_d = 1'b0;
    end
  end

  assign eot_pending = eot_pending_q;
  assign eot_accept  = rst && (state_q == IDLE) && eot_pending_q;
`else
  logic unused_tx_last;
  assign unused_tx_last = tx_last;
  assign eot_pending    = 1'b0;
  assign eot_accept     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    // Ticks only pace an active frame; a tick on the accept edge is deliberately ignored.
    if ((state_q != IDLE) && baud_tick) begin
      tick_cnt_d = boundary ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = START;
          shift_d    = load_byte;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (boundary) begin
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_d   = STOP;
            bit_cnt_d = BW'(DATA_BITS);
            tx_d      = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (frame_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end else if (boundary) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign byte_done = done_q;

endmodule

// File: tb/tb_uart_transmitter_byte.sv
// Randomised bench for uart_transmitter_byte: a tick-counting frame model predicts the line cycle by cycle
// and a mid-bit sampling receiver recovers each byte from tx.
module tb_uart_transmitter_byte;

  localparam int DATA_BITS   = 8;
  localparam int OVERSAMPLE  = 16;
  localparam int STOP_BITS   = 1;
  localparam int FRAME_TICKS = (1 + DATA_BITS + STOP_BITS) * OVERSAMPLE;
  localparam logic [7:0] EOT = 8'h04;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, tx, busy, byte_done;

  int checks = 0;
  int errors = 0;
  bit finished = 1'b0;

  // Reference model state (written only by the model process)
  bit         m_active = 1'b0;
  bit         m_eot_pend = 1'b0;
  bit         m_last = 1'b0;
  int         m_n = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_exp_tx = 1'b1;
  bit         m_exp_done = 1'b0;
  int         m_accepts = 0;
  int         m_frames = 0;
  int         m_samp = -1;
  logic [7:0] m_rx = 8'h00;
  logic       m_rx_start = 1'b1;
  logic       m_rx_stop = 1'b0;

  uart_transmitter_byte #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .STOP_BITS (STOP_BITS),
    .EOT_CHAR  (EOT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic finish_sim();
    if (!finished) begin
      finished = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= DATA_BITS) return b[k-1];
    else return 1'b1;
  endfunction

  function automatic void start_frame(input logic [7:0] b, input bit last);
    m_active   = 1'b1;
    m_n        = 0;
    m_byte     = b;
    m_last     = last;
    m_exp_tx   = 1'b0;
    m_samp     = -1;
    m_rx       = 8'h00;
    m_rx_start = 1'b1;
    m_rx_stop  = 1'b0;
    m_accepts++;
  endfunction

  // Random baud strobe, roughly one tick every three clocks
  initial begin : tick_gen
    forever begin
      @(posedge clk);
      #1 baud_tick = ($urandom_range(0, 2) == 0);
    end
  end

  // Model: predict outputs from the edge's inputs, then compare and sample the line at the falling edge
  initial begin : model
    forever begin
      @(posedge clk);
      m_exp_done = 1'b0;
      if (!rst) begin
        m_active   = 1'b0;
        m_eot_pend = 1'b0;
        m_last     = 1'b0;
        m_exp_tx   = 1'b1;
      end else if (m_active) begin
        if (baud_tick) m_n++;
        if (m_n == FRAME_TICKS) begin
          m_active   = 1'b0;
          m_exp_done = 1'b1;
          m_exp_tx   = 1'b1;
          if (m_last) m_eot_pend = 1'b1;
        end else begin
          m_exp_tx = frame_bit(m_byte, m_n / OVERSAMPLE);
        end
      end else if (m_eot_pend) begin
        m_eot_pend = 1'b0;
        start_frame(EOT, 1'b0);
      end else if (tx_valid) begin
`ifdef UART_TX_AUTO_EOT_EN
        start_frame(tx_data, tx_last);
`else
        start_frame(tx_data, 1'b0);
`endif
      end

      @(negedge clk);
      chk("tx", tx, m_exp_tx);
      chk("busy", busy, m_active);
      chk("byte_done", byte_done, m_exp_done);
      chk("tx_ready", tx_ready, rst && !m_active && !m_eot_pend);
      if (m_active && (m_n % OVERSAMPLE) >= OVERSAMPLE / 2 && (m_n / OVERSAMPLE) > m_samp) begin
        m_samp = m_n / OVERSAMPLE;
        if (m_samp == 0) m_rx_start = tx;
        else if (m_samp <= DATA_BITS) m_rx[m_samp-1] = tx;
        else m_rx_stop = tx;
      end
      if (m_exp_done) begin
        m_frames++;
        chk("rx_byte", m_rx, m_byte);
        chk("rx_framing", {m_rx_start, m_rx_stop}, 2'b01);
        $display("frame %0d sent=%02h received=%02h start=%0b stop=%0b", m_frames, m_byte, m_rx,
                 m_rx_start, m_rx_stop);
      end
    end
  end

  always @(negedge clk) if (errors > 40) finish_sim();

  task automatic wait_accept(input int target);
    int cyc = 0;
    bit timed_out = 1'b0;
    while (m_accepts < target && !timed_out) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 3000) timed_out = 1'b1;
    end
    if (timed_out) chk("accept_timeout", timed_out, 1'b0);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    bit timed_out = 1'b0;
    while ((m_active || m_eot_pend) && !timed_out) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 5000) timed_out = 1'b1;
    end
    if (timed_out) chk("idle_timeout", timed_out, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    tx_data  = b;
    tx_last  = last;
    tx_valid = 1'b1;
    wait_accept(m_accepts + 1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
  endtask

  initial begin : stim
    logic [7:0] burst [3];
    int cyc;
    burst[0] = 8'h31;
    burst[1] = 8'h32;
    burst[2] = 8'h33;

    // Reset held with a pending request: nothing may start
    rst      = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (5) @(posedge clk);
    #1;
    rst      = 1'b1;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    send(8'hA5, 1'b0);
    wait_idle();

    // Valid held across three frames, each accepted in its first idle cycle
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = burst[i];
      wait_accept(m_accepts + 1);
    end
    tx_valid = 1'b0;
    wait_idle();

    // Abort mid-data of 8'h00, then a clean 8'h55
    send(8'h00, 1'b0);
    cyc = 0;
    while (m_n < 3 * OVERSAMPLE && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(8'h55, 1'b0);
    wait_idle();

    // Last-byte marker: EOT follows only when the auto-EOT build is selected
    send(8'h41, 1'b1);
    wait_idle();
    send(8'h41, 1'b0);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
      send(8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    finish_sim();
  end

endmodule
